jumper_physics: RTL

Parametrised successor to the player-sprite motion block. It integrates vertical motion per frame with a fixed-point velocity/gravity model instead of a closed-form jump curve, and adds spring boosts, fall-only landing, configurable horizontal wrap and death detection. It also produces the registered sprite-window hit and texel address for the pixel mux, which feeds the left/right sprite ROMs.

---
 rtl/jumper_physics_if.sv | 37 +++
 rtl/jumper_physics.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/jumper_physics_if.sv
// Game-side bundle for the jumper sprite: frame/game controls and beam position in,
// sprite position, status and registered pixel-window outputs back.
interface jumper_physics_if #(
    parameter int unsigned SPRITE_W = 80,
    parameter int unsigned SPRITE_H = 80
);
    localparam int unsigned CW = $clog2(SPRITE_W);
    localparam int unsigned RW = $clog2(SPRITE_H);

    logic              frame_tick;
    logic [1:0]        game_state;
    logic signed [8:0] delta_x;
    logic              collision;
    logic              spring_hit;
    logic [9:0]        ground_y;
    logic [10:0]       beam_x;
    logic [9:0]        beam_y;

    logic [10:0]       doodle_x;
    logic [9:0]        doodle_y;
    logic              falling;
    logic              facing_left;
    logic              dead;
    logic              draw_en;
    logic [CW-1:0]     sprite_col;
    logic [RW-1:0]     sprite_row;

    modport master (
        output frame_tick, game_state, delta_x, collision, spring_hit, ground_y, beam_x, beam_y,
        input  doodle_x, doodle_y, falling, facing_left, dead, draw_en, sprite_col, sprite_row
    );

    modport slave (
        input  frame_tick, game_state, delta_x, collision, spring_hit, ground_y, beam_x, beam_y,
        output doodle_x, doodle_y, falling, facing_left, dead, draw_en, sprite_col, sprite_row
    );
endinterface

// File: rtl/jumper_physics.sv
// Player-sprite motion: fixed-point vertical integration with gravity, platform/spring
// landing, horizontal wrap and death detection, plus the registered sprite-window lookup.
module jumper_physics #(
    parameter int unsigned SPRITE_W     = 80,
    parameter int unsigned SPRITE_H     = 80,
    parameter int unsigned FRAC_BITS    = 4,
    parameter int unsigned JUMP_VEL     = 144,
    parameter int unsigned SPRING_VEL   = 288,
    parameter int unsigned GRAVITY      = 2,
    parameter int unsigned MAX_FALL     = 160,
    parameter int unsigned X_MIN        = 301,
    parameter int unsigned X_MAX        = 641,
    parameter int unsigned START_X      = 472,
    parameter int unsigned START_Y      = 687,
    parameter int unsigned FIELD_BOTTOM = 767
) (
    input logic             clk,
    input logic             rst,
    jumper_physics_if.slave bus
);
    localparam int unsigned YW   = 11 + FRAC_BITS;
    localparam int unsigned VW   = 10 + FRAC_BITS;
    localparam int unsigned CW   = $clog2(SPRITE_W);
    localparam int unsigned RW   = $clog2(SPRITE_H);
    localparam int unsigned SPAN = X_MAX - X_MIN + 1;

    localparam logic signed [YW-1:0] START_POS = $signed(YW'(START_Y << FRAC_BITS));
    localparam logic signed [VW-1:0] JUMP_V    = -$signed(VW'(JUMP_VEL));
    localparam logic signed [VW-1:0] SPRING_V  = -$signed(VW'(SPRING_VEL));
    localparam logic signed [VW-1:0] GRAV_V    = $signed(VW'(GRAVITY));
    localparam logic signed [VW-1:0] MAX_V     = $signed(VW'(MAX_FALL));
    localparam logic signed [11:0]   XMIN_S    = $signed(12'(X_MIN));
    localparam logic signed [11:0]   XMAX_S    = $signed(12'(X_MAX));
    localparam logic signed [11:0]   SPAN_S    = $signed(12'(SPAN));
    localparam logic signed [11:0]   LAND_OFS  = $signed(12'(SPRITE_H + 1));

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t               state;
    logic [10:0]          x;
    logic signed [YW-1:0] pos_y;
    logic signed [VW-1:0] vel;
    logic                 falling_q, facing_q, dead_q;
    logic                 draw_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [9:0]           doodle_y;

    logic                 vel_pos, spring_land, land, dies;
    logic signed [VW-1:0] vel_g, vel_n;
    logic signed [YW-1:0] pos_n;
    logic signed [11:0]   land_row, nx_raw;
    logic [10:0]          x_n;

    assign doodle_y = pos_y[FRAC_BITS +: 10];

    // Next-frame kinematics for a RUN tick
    always_comb begin
        vel_pos     = !vel[VW-1] && (vel != '0);
        spring_land = bus.spring_hit && vel_pos;
        land        = spring_land || (bus.collision && vel_pos);
        vel_g       = vel + GRAV_V;
        if (vel_g > MAX_V) vel_g = MAX_V;
        vel_n = spring_land ? SPRING_V : (land ? JUMP_V : vel_g);

        land_row = $signed({2'b00, bus.ground_y}) - LAND_OFS;
        pos_n    = land ? ($signed(YW'(land_row)) <<< FRAC_BITS) : (pos_y + YW'(vel_n));
        if (pos_n[YW-1]) begin
            pos_n = '0;
            vel_n = '0;
        end
        dies = pos_n[YW-1:FRAC_BITS] > 11'(FIELD_BOTTOM);

        nx_raw = $signed({1'b0, x}) + 12'(bus.delta_x);
        if (nx_raw < XMIN_S)      x_n = 11'(nx_raw + SPAN_S);
        else if (nx_raw > XMAX_S) x_n = 11'(nx_raw - SPAN_S);
        else                      x_n = 11'(nx_raw);
    end

    // Game FSM; a menu request restarts from any state without waiting for a tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            x         <= 11'(START_X);
            pos_y     <= START_POS;
            vel       <= '0;
            falling_q <= 1'b0;
            facing_q  <= 1'b0;
            dead_q    <= 1'b0;
        end else if (bus.game_state == 2'd0) begin
            state     <= IDLE;
            x         <= 11'(START_X);
            pos_y     <= START_POS;
            vel       <= '0;
            falling_q <= 1'b0;
            facing_q  <= 1'b0;
            dead_q    <= 1'b0;
        end else if (bus.frame_tick) begin
            case (state)
                IDLE: begin
                    if (bus.game_state == 2'd1) begin
                        vel   <= JUMP_V;
                        state <= RUN;
                    end
                end
                RUN: begin
                    vel       <= vel_n;
                    pos_y     <= pos_n;
                    falling_q <= !vel_n[VW-1] && (vel_n != '0);
                    x         <= x_n;
                    if (bus.delta_x < 0)      facing_q <= 1'b1;
                    else if (bus.delta_x > 0) facing_q <= 1'b0;
                    if (dies) begin
                        state  <= DEAD;
                        dead_q <= 1'b1;
                    end
                end
                DEAD: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Sprite window lookup, one cycle behind the beam
    logic [11:0] x_hi;
    logic [10:0] y_hi;
    logic        in_win;

    always_comb begin
        x_hi   = {1'b0, x} + 12'(SPRITE_W);
        y_hi   = {1'b0, doodle_y} + 11'(SPRITE_H);
        in_win = (bus.beam_x >= x) && ({1'b0, bus.beam_x} < x_hi) &&
                 (bus.beam_y >= doodle_y) && ({1'b0, bus.beam_y} < y_hi);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            draw_q <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            draw_q <= in_win;
            col_q  <= in_win ? CW'(bus.beam_x - x) : '0;
            row_q  <= in_win ? RW'(bus.beam_y - doodle_y) : '0;
        end
    end

    assign bus.doodle_x    = x;
    assign bus.doodle_y    = doodle_y;
    assign bus.falling     = falling_q;
    assign bus.facing_left = facing_q;
    assign bus.dead        = dead_q;
    assign bus.draw_en     = draw_q;
    assign bus.sprite_col  = col_q;
    assign bus.sprite_row  = row_q;
endmodule
